// File: rtl/ad7763_ctrl_pkg.sv
// Shared types and constants for the AD7763 control-word port arbiter.
package ad7763_ctrl_pkg;

    localparam int AD_WORD_W   = 32;

    // Control-word layout: register address in the upper half, register data in the lower half.
    localparam int AD_ADDR_MSB = 31;
    localparam int AD_ADDR_LSB = 16;
    localparam int AD_DATA_MSB = 15;
    localparam int AD_DATA_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } ctrl_state_t;

    function automatic logic [AD_WORD_W-1:0] ad7763_word(
        input logic [AD_ADDR_MSB-AD_ADDR_LSB:0] addr,
        input logic [AD_DATA_MSB-AD_DATA_LSB:0] data
    );
        logic [AD_WORD_W-1:0] w;
        w = '0;
        w[AD_ADDR_MSB:AD_ADDR_LSB] = addr;
        w[AD_DATA_MSB:AD_DATA_LSB] = data;
        return w;
    endfunction

endpackage

// File: rtl/ad7763_rr_arbiter.sv
// Combinational one-hot round-robin grant; the search starts at i_ptr and wraps.
module ad7763_rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    logic             w_found;
    logic [IDX_W-1:0] w_pos;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_pos   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_pos = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
            if (!w_found && i_req[w_pos]) begin
                w_found        = 1'b1;
                o_grant[w_pos] = 1'b1;
                o_idx          = w_pos;
            end
        end
        o_any = w_found;
    end

endmodule

// File: rtl/ad7763_ctrl_arbiter.sv
// Round-robin sharing of the AD7763 control-word serializer between NUM_REQ requesters.
// Optional watchdog enabled by defining AD7763_CTRL_TIMEOUT_EN.
module ad7763_ctrl_arbiter
    import ad7763_ctrl_pkg::*;
#(
    parameter  int NUM_REQ        = 4,
    parameter  int WORD_W         = AD_WORD_W,
    parameter  int GAP_CYCLES     = 16,
    parameter  int TIMEOUT_CYCLES = 4096,
    localparam int IDX_W          = $clog2(NUM_REQ)
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*WORD_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      m_valid,
    output logic [WORD_W-1:0]         m_data,
    input  logic                      m_ready,
    input  logic                      m_done,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      busy,
    output logic                      err_timeout
);

    localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    ctrl_state_t        r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_ptr, r_grant_id, w_idx;
    logic [NUM_REQ-1:0] w_grant;
    logic               w_any, w_accept, w_wd_expired;
    logic [WORD_W-1:0]  r_m_data;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [WORD_W-1:0]  w_words [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_words[gi] = req_data[gi*WORD_W +: WORD_W];
    end

    ad7763_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

`ifdef AD7763_CTRL_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_err;

    assign w_wd_expired = (r_state == ST_ISSUE || r_state == ST_WAIT_DONE) &&
                          (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    // Restarts on every state change so ISSUE and WAIT_DONE are each timed from entry.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wd_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_state_nxt != r_state)
                r_wd_cnt <= '0;
            else if (r_state == ST_ISSUE || r_state == ST_WAIT_DONE)
                r_wd_cnt <= r_wd_cnt + WD_W'(1);
            if (w_wd_expired)
                r_err <= 1'b1;
        end
    end

    assign err_timeout = r_err;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign w_wd_expired = 1'b0;
    assign err_timeout  = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_wd_expired)
                    w_state_nxt = ST_GAP;
                else if (m_ready)
                    w_state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (w_wd_expired)
                    w_state_nxt = ST_GAP;
                else if (m_done)
                    w_state_nxt = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
            end
            ST_GAP: begin
                if (r_gap_cnt == '0)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_grant_id <= '0;
            r_m_data   <= '0;
            r_gap_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_m_data   <= w_words[w_idx];
                r_grant_id <= w_idx;
                r_ptr      <= (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + IDX_W'(1);
            end
            // GAP lasts GAP_CYCLES cycles: loaded on entry, leaves when it reads zero.
            if (w_state_nxt == ST_GAP && r_state != ST_GAP)
                r_gap_cnt <= GAP_W'(GAP_LOAD);
            else if (r_state == ST_GAP && r_gap_cnt != '0)
                r_gap_cnt <= r_gap_cnt - GAP_W'(1);
        end
    end

    assign req_ready = (r_state == ST_IDLE) ? w_grant : '0;
    assign m_valid   = (r_state == ST_ISSUE);
    assign m_data    = r_m_data;
    assign grant_id  = r_grant_id;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ad7763_ctrl_arbiter.sv
// Directed self-checking bench for ad7763_ctrl_arbiter (NUM_REQ=4, GAP_CYCLES=16, TIMEOUT_CYCLES=64).
module tb_ad7763_ctrl_arbiter;
    import ad7763_ctrl_pkg::*;

    localparam int NREQ = 4;
    localparam int WW   = 32;
    localparam int GAP  = 16;
    localparam int TMO  = 64;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*WW-1:0] req_data = '0;
    logic [NREQ-1:0]   req_ready;
    logic              m_valid;
    logic [WW-1:0]     m_data;
    logic              m_ready = 1'b0;
    logic              m_done = 1'b0;
    logic [1:0]        grant_id;
    logic              busy;
    logic              err_timeout;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 aclk = ~aclk;

    ad7763_ctrl_arbiter #(
        .NUM_REQ(NREQ), .WORD_W(WW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .m_done(m_done),
        .grant_id(grant_id), .busy(busy), .err_timeout(err_timeout)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        m_ready   = 1'b0;
        m_done    = 1'b0;
        aresetn   = 1'b0;
        step();
        step();
        aresetn = 1'b1;
        #1;
    endtask

    task automatic set_word(input int i, input logic [WW-1:0] w);
        req_data[i*WW +: WW] = w;
    endtask

    // n counts cycles with the caller's cycle numbered 'start'; bounded to 200 cycles.
    task automatic wait_grant(input int start, output int n);
        n = start;
        #1;
        while (req_ready == '0 && n < start + 200) begin
            step();
            n++;
        end
        chk("grant_seen", |req_ready, 1'b1);
    endtask

    // One full transfer: grant, issue, accept, done. Returns in the cycle after m_done.
    task automatic serve(input string tag, input int idx, input logic [WW-1:0] word, input int exp_wait);
        int n;
        logic [NREQ-1:0] oh;
        oh = NREQ'(1) << idx;
        wait_grant(1, n);
        if (exp_wait >= 0) chk({tag, ".wait"}, n, exp_wait);
        chk({tag, ".ready"}, req_ready, oh);
        step();
        req_valid[idx] = 1'b0;
        chk({tag, ".m_valid"}, m_valid, 1'b1);
        chk({tag, ".m_data"}, m_data, word);
        chk({tag, ".grant_id"}, grant_id, idx);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk({tag, ".m_valid_drop"}, m_valid, 1'b0);
        m_done = 1'b1;
        step();
        m_done = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic bad;

        // Reset state
        do_reset();
        chk("rst.m_valid", m_valid, 1'b0);
        chk("rst.m_data", m_data, 32'h0);
        chk("rst.grant_id", grant_id, 2'd0);
        chk("rst.busy", busy, 1'b0);
        chk("rst.err", err_timeout, 1'b0);
        chk("rst.req_ready", req_ready, 4'b0000);

        // Single request: accept at T, issue at T+1, m_ready at T+3, drop at T+4
        set_word(0, ad7763_word(16'h0001, 16'h0023));
        req_valid = 4'b0001;
        #1;
        chk("single.ready", req_ready, 4'b0001);
        step();
        req_valid = '0;
        chk("single.m_valid", m_valid, 1'b1);
        chk("single.m_data", m_data, 32'h0001_0023);
        step();
        step();
        m_ready = 1'b1;
        chk("single.hold", m_valid, 1'b1);
        step();
        m_ready = 1'b0;
        chk("single.drop", m_valid, 1'b0);
        chk("single.busy_wait", busy, 1'b1);
        m_done = 1'b1;
        step();
        m_done = 1'b0;
        repeat (15) step();
        chk("single.busy_gap_end", busy, 1'b1);
        step();
        chk("single.idle", busy, 1'b0);

        // Contention: all four valid, strict rotation, 17 cycles from each m_done
        do_reset();
        for (int i = 0; i < NREQ; i++) set_word(i, 32'h0000_00A0 + i);
        req_valid = 4'b1111;
        for (int g = 0; g < NREQ; g++)
            serve($sformatf("cont%0d", g), g, 32'h0000_00A0 + g, (g == 0) ? -1 : GAP + 1);

        // Fairness wrap: last grant 2, then 0 and 3 pending -> 3 before 0
        do_reset();
        set_word(2, 32'hC0DE_0002);
        req_valid = 4'b0100;
        serve("fair.p2", 2, 32'hC0DE_0002, -1);
        set_word(0, 32'hC0DE_0000);
        set_word(3, 32'hC0DE_0003);
        req_valid = 4'b1001;
        serve("fair.p3", 3, 32'hC0DE_0003, GAP + 1);
        serve("fair.p0", 0, 32'hC0DE_0000, GAP + 1);

        // Backpressure with a spurious m_done while in ISSUE
        do_reset();
        set_word(1, ad7763_word(16'h0002, 16'h55AA));
        req_valid = 4'b0010;
        wait_grant(1, n);
        step();
        set_word(0, 32'h0BAD_0000);
        req_valid = 4'b0001;
        bad = 1'b0;
        for (int c = 0; c < 50; c++) begin
            m_done = (c == 20);
            #1;
            if (m_valid !== 1'b1 || m_data !== 32'h0002_55AA || req_ready !== 4'b0000) bad = 1'b1;
            step();
        end
        m_done = 1'b0;
        chk("bp.stable", bad, 1'b0);
        chk("bp.still_valid", m_valid, 1'b1);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        repeat (10) step();
        chk("bp.wait_done_busy", busy, 1'b1);
        chk("bp.no_grant", req_ready, 4'b0000);
        m_done = 1'b1;
        step();
        m_done = 1'b0;
        serve("bp.next", 0, 32'h0BAD_0000, GAP + 1);

        // Reset during WAIT_DONE: immediate clear, no re-issue
        do_reset();
        set_word(2, 32'hDEAD_0002);
        req_valid = 4'b0100;
        wait_grant(1, n);
        step();
        req_valid = '0;
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk("mrst.pre_busy", busy, 1'b1);
        chk("mrst.pre_grant", grant_id, 2'd2);
        #2;
        aresetn = 1'b0;
        #1;
        chk("mrst.m_valid", m_valid, 1'b0);
        chk("mrst.busy", busy, 1'b0);
        chk("mrst.m_data", m_data, 32'h0);
        chk("mrst.grant_id", grant_id, 2'd0);
        @(posedge aclk);
        #3;
        aresetn = 1'b1;
        bad = 1'b0;
        repeat (30) begin
            step();
            if (m_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        chk("mrst.no_reissue", bad, 1'b0);

        // Watchdog: never pulse m_done after the word is accepted
        do_reset();
        set_word(1, 32'h7777_0001);
        req_valid = 4'b0010;
        wait_grant(1, n);
        step();
        req_valid = '0;
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        set_word(3, 32'h7777_0003);
        req_valid = 4'b1000;
`ifdef AD7763_CTRL_TIMEOUT_EN
        repeat (TMO - 1) step();
        chk("tmo.not_yet", err_timeout, 1'b0);
        step();
        chk("tmo.err", err_timeout, 1'b1);
        chk("tmo.busy_gap", busy, 1'b1);
        chk("tmo.no_grant", req_ready, 4'b0000);
        serve("tmo.next", 3, 32'h7777_0003, GAP + 1);
        chk("tmo.sticky", err_timeout, 1'b1);
`else
        repeat (100) step();
        chk("tmo.none", err_timeout, 1'b0);
        chk("tmo.waiting", busy, 1'b1);
        chk("tmo.no_grant", req_ready, 4'b0000);
        m_done = 1'b1;
        step();
        m_done = 1'b0;
        serve("tmo.next", 3, 32'h7777_0003, GAP + 1);
        chk("tmo.none_after", err_timeout, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
